// File: rtl/mux_4_pkg.sv
// Shared definitions for the mux_4 slice: binary select encoding.
package mux_4_pkg;

    typedef enum logic [1:0] {
        SEL_D0 = 2'b00,
        SEL_D1 = 2'b01,
        SEL_D2 = 2'b10,
        SEL_D3 = 2'b11
    } sel_e;

endpackage

// File: rtl/mux_4_if.sv
// Bundle of mux_4 data, select and valid signals; master drives inputs, slave is the mux.
interface mux_4_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [1:0]       s;
    logic             in_valid;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             out_valid;

    modport master (
        output d0, d1, d2, d3, s, in_valid,
        input  y, y_q, out_valid
    );

    modport slave (
        input  d0, d1, d2, d3, s, in_valid,
        output y, y_q, out_valid
    );
endinterface

// File: rtl/mux_4_reg.sv
// Output register stage for mux_4: captures the selected word when valid, async active-low reset.
module mux_4_reg #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_vld,
    output logic [WIDTH-1:0] o_q,
    output logic             o_vld
);
    logic [WIDTH-1:0] r_q;
    logic             r_vld;

    // Data holds when not valid; the valid flag is a one-cycle pulse per capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q   <= '0;
            r_vld <= 1'b0;
        end else begin
            if (i_vld) begin
                r_q <= i_d;
            end
            r_vld <= i_vld;
        end
    end

    assign o_q   = r_q;
    assign o_vld = r_vld;
endmodule

// File: rtl/mux_4.sv
// 4:1 word multiplexer with combinational output and an optional registered copy.
module mux_4
    import mux_4_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter bit REG_OUT = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    mux_4_if.slave bus
);
    logic [WIDTH-1:0] w_y;

    // An unknown select propagates as X rather than silently picking d0.
    always_comb begin
        case (bus.s)
            SEL_D0:  w_y = bus.d0;
            SEL_D1:  w_y = bus.d1;
            SEL_D2:  w_y = bus.d2;
            SEL_D3:  w_y = bus.d3;
            default: w_y = 'x;
        endcase
    end

    assign bus.y = w_y;

    generate
        if (REG_OUT) begin : g_reg
            mux_4_reg #(
                .WIDTH (WIDTH)
            ) u_reg (
                .i_clk   (clk),
                .i_rst_n (rst_n),
                .i_d     (w_y),
                .i_vld   (bus.in_valid),
                .o_q     (bus.y_q),
                .o_vld   (bus.out_valid)
            );
        end else begin : g_comb
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst_n;
            assign bus.y_q          = w_y;
            assign bus.out_valid    = bus.in_valid;
        end
    endgenerate
endmodule

// File: tb/tb_mux_4.sv
// Bench for mux_4: registered and combinational builds driven together against a word-array model.
module tb_mux_4;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mux_4_if #(.WIDTH(W)) bus_r ();
    mux_4_if #(.WIDTH(W)) bus_c ();

    mux_4 #(.WIDTH(W), .REG_OUT(1'b1)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus_r.slave));
    mux_4 #(.WIDTH(W), .REG_OUT(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the four words as an array indexed by select.
    logic [W-1:0] m_d [4];
    int           m_s;
    logic         m_iv;
    logic [W-1:0] exp_yq;
    logic         exp_ov;

    logic [21:0] tbl [18];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_y();
        return m_d[m_s];
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] d, input logic [1:0] sel, input logic iv);
        bus_r.d0 = a; bus_r.d1 = b; bus_r.d2 = c; bus_r.d3 = d; bus_r.s = sel; bus_r.in_valid = iv;
        bus_c.d0 = a; bus_c.d1 = b; bus_c.d2 = c; bus_c.d3 = d; bus_c.s = sel; bus_c.in_valid = iv;
        m_d[0] = a; m_d[1] = b; m_d[2] = c; m_d[3] = d;
        m_s  = int'(sel);
        m_iv = iv;
    endtask

    task automatic check_comb(input string tag);
        check({tag, "_y"},     32'(bus_r.y),         32'(ref_y()));
        check({tag, "_yc"},    32'(bus_c.y),         32'(ref_y()));
        check({tag, "_yqc"},   32'(bus_c.y_q),       32'(ref_y()));
        check({tag, "_ovc"},   32'(bus_c.out_valid), 32'(m_iv));
    endtask

    // Advance one rising edge, update the expected register contents, then compare.
    task automatic clk_step(input string tag);
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (m_iv) exp_yq = ref_y();
            exp_ov = m_iv;
        end
        check({tag, "_yq"}, 32'(bus_r.y_q),       32'(exp_yq));
        check({tag, "_ov"}, 32'(bus_r.out_valid), 32'(exp_ov));
    endtask

    initial begin
        tbl = '{
            {16'h1248, 2'd0, 4'h1}, {16'h1248, 2'd1, 4'h2}, {16'h1248, 2'd2, 4'h4},
            {16'h1248, 2'd3, 4'h8}, {16'hF000, 2'd0, 4'hF}, {16'hF000, 2'd1, 4'h0},
            {16'h0F00, 2'd1, 4'hF}, {16'h00F0, 2'd2, 4'hF}, {16'h000F, 2'd3, 4'hF},
            {16'h000F, 2'd0, 4'h0}, {16'hABCD, 2'd0, 4'hA}, {16'hABCD, 2'd1, 4'hB},
            {16'hABCD, 2'd2, 4'hC}, {16'hABCD, 2'd3, 4'hD}, {16'h5A3C, 2'd2, 4'h3},
            {16'h5A3C, 2'd3, 4'hC}, {16'h7E81, 2'd1, 4'hE}, {16'h7E81, 2'd0, 4'h7}
        };

        drive('0, '0, '0, '0, 2'd0, 1'b0);
        exp_yq = '0;
        exp_ov = 1'b0;
        #1;
        check("rst_yq", 32'(bus_r.y_q),       32'h0);
        check("rst_ov", 32'(bus_r.out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed one-hot words, sweep the select.
        for (int i = 0; i < 4; i++) begin
            drive(4'h1, 4'h2, 4'h4, 4'h8, 2'(i), 1'b0);
            #1;
            check($sformatf("sweep%0d", i), 32'(bus_r.y), 32'(1 << i));
            check_comb($sformatf("sweep%0d", i));
        end

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i][21:18], tbl[i][17:14], tbl[i][13:10], tbl[i][9:6], tbl[i][5:4], 1'b0);
            #1;
            check($sformatf("tbl%0d", i), 32'(bus_r.y), 32'(tbl[i][3:0]));
        end

        // Disturb only the unselected inputs.
        for (int i = 0; i < 6; i++) begin
            drive(4'($urandom), 4'h6, 4'($urandom), 4'($urandom), 2'd1, 1'b0);
            #1;
            check($sformatf("nonsel%0d", i), 32'(bus_r.y), 32'h6);
        end

        @(negedge clk);
        drive(4'h1, 4'h2, 4'hA, 4'h8, 2'd2, 1'b1);
        clk_step("cap");
        check("cap_yq_const", 32'(bus_r.y_q), 32'hA);
        check("cap_ov_const", 32'(bus_r.out_valid), 32'h1);
        @(negedge clk);
        drive(4'h1, 4'h2, 4'h5, 4'h8, 2'd2, 1'b0);
        clk_step("hold");
        check("hold_yq_const", 32'(bus_r.y_q), 32'hA);
        check("hold_ov_const", 32'(bus_r.out_valid), 32'h0);

        // Async reset landing between edges while out_valid is high.
        @(negedge clk);
        drive(4'hC, 4'h2, 4'h4, 4'h8, 2'd0, 1'b1);
        clk_step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        exp_yq = '0;
        exp_ov = 1'b0;
        check("arst_yq", 32'(bus_r.y_q),       32'h0);
        check("arst_ov", 32'(bus_r.out_valid), 32'h0);
        drive(4'hC, 4'h2, 4'h9, 4'h8, 2'd2, 1'b1);
        #1;
        check("arst_y", 32'(bus_r.y), 32'h9);
        clk_step("in_rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  2'($urandom_range(0, 3)), 1'($urandom));
            #1;
            check_comb($sformatf("rnd%0d", i));
            clk_step($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
